// File: rtl/v_hier_qvec_monitor.sv
// v_hier_qvec_monitor: watches the qvec bus and logs per-bit changes.
// Change events go into a FWFT FIFO; per-bit toggle counts saturate.
module v_hier_qvec_monitor #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       qvec,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_data,
    output logic             overflow,
    input  logic             clr,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_value
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]       q_d;
    logic             primed;
    logic [3:0]       chg;
    logic             ev;
    logic [7:0]       mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      occ;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] cnt [4];

    assign chg   = qvec ^ q_d;
    assign ev    = primed && (chg != 4'd0);
    assign occ   = wptr - rptr;
    assign empty = (occ == '0);
    assign full  = (occ == (AW+1)'(DEPTH));
    assign pop   = !empty && ev_ready;
    // a same-cycle pop frees the slot a full-FIFO push needs
    assign push  = ev && (!full || pop);

    assign ev_valid  = !empty;
    assign ev_data   = mem[rptr[AW-1:0]];
    assign cnt_value = cnt[cnt_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            q_d      <= 4'd0;
            primed   <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            q_d    <= qvec;
            primed <= 1'b1;
            if (push) begin
                mem[wptr[AW-1:0]] <= {chg, qvec};
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
            if (clr) begin
                overflow <= 1'b0;
            end else if (ev && full && !pop) begin
                overflow <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (clr) begin
                    cnt[i] <= '0;
                end else if (primed && chg[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end
endmodule
